mcu_link_router: RTL and testbench

- Sits between the MCU SPI byte deserializer and the MCU-facing slave blocks: sysctrl, HID, OSD and SD-card.
- The first byte of every MCU message selects a target.
- The router replays the rest of the message to that target as a fresh message, then returns that target's reply bytes to the MCU.
- One router instance replaces the hand-wired fan-out of strobe, start and data, and the reply-byte OR-ing, in the top level.

---
 rtl/mcu_link_pkg.sv | 23 ++
 rtl/mcu_link_reply_mux.sv | 53 +++++
 rtl/mcu_link_router.sv | 141 ++++++++++++++
 tb/tb_mcu_link_router.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu_link_pkg.sv
// mcu_link_pkg: shared types and constants for the MCU link router.
//   state_t     : router FSM state encoding (2 bits)
//   TGT_*       : target ids of the MCU-facing slave blocks
//   PRESENCE_BYTE / ERR_BYTE / IDLE_BYTE : constant reply bytes
package mcu_link_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    ROUTE   = 2'd2,
    DISCARD = 2'd3
  } state_t;

  localparam logic [2:0] TGT_SYS = 3'd0;
  localparam logic [2:0] TGT_HID = 3'd1;
  localparam logic [2:0] TGT_OSD = 3'd2;
  localparam logic [2:0] TGT_SDC = 3'd3;

  localparam logic [7:0] PRESENCE_BYTE = 8'hA5;
  localparam logic [7:0] ERR_BYTE      = 8'hFF;
  localparam logic [7:0] IDLE_BYTE     = 8'h00;

endpackage

// File: rtl/mcu_link_reply_mux.sv
// mcu_link_reply_mux: registered reply byte back to the MCU.
// Selects the addressed target's reply byte while routing, otherwise
// a constant that depends on the router state being entered.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   state_nxt     : state the router enters on this edge
//   sel           : target id valid for that state
//   presence_byte : reply while the id byte is being accepted
//   tgt_dout      : packed reply bytes, target k at [8k+7:8k]
//   out_data      : registered reply byte
module mcu_link_reply_mux
  import mcu_link_pkg::*;
#(
  parameter int NUM_TARGETS = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  state_t                     state_nxt,
  input  logic [2:0]                 sel,
  input  logic [7:0]                 presence_byte,
  input  logic [8*NUM_TARGETS-1:0]   tgt_dout,
  output logic [7:0]                 out_data
);

  logic [7:0] routed;
  logic [7:0] reply_nxt;

  // Loop compare instead of a variable part-select keeps ids beyond
  // NUM_TARGETS from indexing past the bus; they simply read zero.
  always_comb begin
    routed = 8'h00;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (sel == 3'(k)) routed = tgt_dout[8*k +: 8];
    end
  end

  always_comb begin
    reply_nxt = IDLE_BYTE;
    case (state_nxt)
      IDLE:    reply_nxt = IDLE_BYTE;
      SELECT:  reply_nxt = presence_byte;
      ROUTE:   reply_nxt = routed;
      DISCARD: reply_nxt = ERR_BYTE;
      default: reply_nxt = IDLE_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) out_data <= IDLE_BYTE;
    else          out_data <= reply_nxt;
  end

endmodule

// File: rtl/mcu_link_router.sv
// mcu_link_router: routes MCU SPI messages to one of NUM_TARGETS slave
// blocks. The first byte of a message selects the target; the remaining
// bytes are replayed to it as a fresh message and its reply bytes are
// returned to the MCU.
// Optional build macro: MCU_LINK_MSG_TIMEOUT_EN -- abandons an open
// message after TIMEOUT_CYCLES cycles without an in_strobe.
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   in_strobe/in_start/in_data : byte from the MCU deserializer
//   out_data               : reply byte to the MCU
//   tgt_strobe/tgt_start/tgt_data : forwarded byte (one-hot strobe)
//   tgt_dout               : per-target reply bytes
//   active_tgt             : currently selected target id
//   route_err              : pulse on bad id or timeout abort
//
// state   | meaning
// IDLE    | no open message; non-start bytes ignored, reply 00
// SELECT  | id byte accepted, reply A5; next byte opens the target msg
// ROUTE   | forwarding bytes to active_tgt, reply from that target
// DISCARD | bad id; bytes swallowed until next start, reply FF
module mcu_link_router
  import mcu_link_pkg::*;
#(
  parameter int          NUM_TARGETS    = 4,
  parameter logic [7:0]  PRESENCE_BYTE  = 8'hA5,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd8_600_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_strobe,
  input  logic                       in_start,
  input  logic [7:0]                 in_data,
  output logic [7:0]                 out_data,
  output logic [NUM_TARGETS-1:0]     tgt_strobe,
  output logic                       tgt_start,
  output logic [7:0]                 tgt_data,
  input  logic [8*NUM_TARGETS-1:0]   tgt_dout,
  output logic [2:0]                 active_tgt,
  output logic                       route_err
);

  state_t                   state, state_nxt;
  logic [2:0]               id_nxt;
  logic                     id_bad, id_bad_nxt;
  logic [NUM_TARGETS-1:0]   strobe_nxt;
  logic                     start_nxt;
  logic [7:0]               data_nxt;
  logic                     err_nxt;
  logic                     timeout;

`ifdef MCU_LINK_MSG_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Holds at 1 once expired; the FSM has left for IDLE by then.
  always_ff @(posedge clk) begin
    if (!reset_n)                               tmo_cnt <= TIMEOUT_CYCLES;
    else if (in_strobe)                         tmo_cnt <= TIMEOUT_CYCLES;
    else if (state != IDLE && tmo_cnt != 32'd1) tmo_cnt <= tmo_cnt - 32'd1;
  end

  assign timeout = (state != IDLE) && (tmo_cnt == 32'd1);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    id_nxt     = active_tgt;
    id_bad_nxt = id_bad;
    strobe_nxt = '0;
    start_nxt  = 1'b0;
    data_nxt   = tgt_data;
    err_nxt    = 1'b0;

    if (in_strobe && in_start) begin
      // A new start always wins; it also closes an open ROUTE quietly.
      state_nxt  = SELECT;
      id_nxt     = in_data[2:0];
      id_bad_nxt = (in_data[7:3] != 5'd0) || (32'(in_data[2:0]) >= NUM_TARGETS);
    end else if (in_strobe) begin
      case (state)
        SELECT: begin
          if (id_bad) begin
            state_nxt = DISCARD;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ROUTE;
            start_nxt = 1'b1;
            data_nxt  = in_data;
            for (int k = 0; k < NUM_TARGETS; k++)
              strobe_nxt[k] = (active_tgt == 3'(k));
          end
        end
        ROUTE: begin
          data_nxt = in_data;
          for (int k = 0; k < NUM_TARGETS; k++)
            strobe_nxt[k] = (active_tgt == 3'(k));
        end
        default: ;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      active_tgt <= 3'd0;
      id_bad     <= 1'b0;
      tgt_strobe <= '0;
      tgt_start  <= 1'b0;
      tgt_data   <= 8'h00;
      route_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      active_tgt <= id_nxt;
      id_bad     <= id_bad_nxt;
      tgt_strobe <= strobe_nxt;
      tgt_start  <= start_nxt;
      tgt_data   <= data_nxt;
      route_err  <= err_nxt;
    end
  end

  mcu_link_reply_mux #(
    .NUM_TARGETS (NUM_TARGETS)
  ) u_reply_mux (
    .clk           (clk),
    .reset_n       (reset_n),
    .state_nxt     (state_nxt),
    .sel           (id_nxt),
    .presence_byte (PRESENCE_BYTE),
    .tgt_dout      (tgt_dout),
    .out_data      (out_data)
  );

endmodule

// File: tb/tb_mcu_link_router.sv
module tb_mcu_link_router;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_strobe = 1'b0;
  logic        in_start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [7:0]  out_data;
  logic [3:0]  tgt_strobe;
  logic        tgt_start;
  logic [7:0]  tgt_data;
  logic [31:0] tgt_dout = 32'h0;
  logic [2:0]  active_tgt;
  logic        route_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mcu_link_router #(
    .NUM_TARGETS    (4),
    .PRESENCE_BYTE  (8'hA5),
    .TIMEOUT_CYCLES (32'd16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_strobe  (in_strobe),
    .in_start   (in_start),
    .in_data    (in_data),
    .out_data   (out_data),
    .tgt_strobe (tgt_strobe),
    .tgt_start  (tgt_start),
    .tgt_data   (tgt_data),
    .tgt_dout   (tgt_dout),
    .active_tgt (active_tgt),
    .route_err  (route_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents one byte for one cycle and returns at the
  // next negedge, where the registered response to that byte is visible.
  task automatic send(input logic st, input logic [7:0] d);
    in_strobe = 1'b1;
    in_start  = st;
    in_data   = d;
    @(negedge clk);
    in_strobe = 1'b0;
    in_start  = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_strobe", 32'(tgt_strobe), 32'h0);
    chk("rst_start",  32'(tgt_start),  32'h0);
    chk("rst_data",   32'(tgt_data),   32'h0);
    chk("rst_out",    32'(out_data),   32'h00);
    chk("rst_active", 32'(active_tgt), 32'h0);
    chk("rst_err",    32'(route_err),  32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    send(1'b0, 8'h33);
    chk("idle_ignore_strobe", 32'(tgt_strobe), 32'h0);
    chk("idle_out", 32'(out_data), 32'h00);

    // Message {start:01, 03, 00}
    send(1'b1, 8'h01);
    chk("sel1_out", 32'(out_data), 32'hA5);
    chk("sel1_active", 32'(active_tgt), 32'h1);
    chk("sel1_strobe", 32'(tgt_strobe), 32'h0);
    send(1'b0, 8'h03);
    chk("m1b1_strobe", 32'(tgt_strobe), 32'h2);
    chk("m1b1_start", 32'(tgt_start), 32'h1);
    chk("m1b1_data", 32'(tgt_data), 32'h03);
    send(1'b0, 8'h00);
    chk("m1b2_strobe", 32'(tgt_strobe), 32'h2);
    chk("m1b2_start", 32'(tgt_start), 32'h0);
    chk("m1b2_data", 32'(tgt_data), 32'h00);
    @(negedge clk);
    chk("m1_strobe_pulse", 32'(tgt_strobe), 32'h0);

    // Reply path from target 0; the target updates its byte on the edge
    // after it sees its strobe, as a registered slave would.
    send(1'b1, 8'h00);
    send(1'b0, 8'h11);
    chk("t0_strobe", 32'(tgt_strobe), 32'h1);
    chk("t0_start", 32'(tgt_start), 32'h1);
    @(posedge clk); #1 tgt_dout[7:0] = 8'h5C;
    @(negedge clk);
    chk("t0_reply_not_yet", 32'(out_data), 32'h00);
    @(negedge clk);
    chk("t0_reply_5c", 32'(out_data), 32'h5C);
    send(1'b0, 8'h22);
    chk("t0b2_strobe", 32'(tgt_strobe), 32'h1);
    @(posedge clk); #1 tgt_dout[7:0] = 8'h42;
    @(negedge clk);
    chk("t0_reply_hold", 32'(out_data), 32'h5C);
    @(negedge clk);
    chk("t0_reply_42", 32'(out_data), 32'h42);

    // Out-of-range id
    send(1'b1, 8'h07);
    chk("bad_sel_out", 32'(out_data), 32'hA5);
    send(1'b0, 8'h10);
    chk("bad_err", 32'(route_err), 32'h1);
    chk("bad_strobe", 32'(tgt_strobe), 32'h0);
    chk("bad_out", 32'(out_data), 32'hFF);
    @(negedge clk);
    chk("bad_err_pulse", 32'(route_err), 32'h0);
    send(1'b0, 8'h55);
    chk("discard_strobe", 32'(tgt_strobe), 32'h0);
    chk("discard_out", 32'(out_data), 32'hFF);
    chk("discard_err", 32'(route_err), 32'h0);

    // Non-zero upper id bits also reject, even with a valid low id
    send(1'b1, 8'h09);
    send(1'b0, 8'h20);
    chk("hibits_err", 32'(route_err), 32'h1);
    chk("hibits_strobe", 32'(tgt_strobe), 32'h0);

    // Highest valid id, then mid-ROUTE restart to target 2
    send(1'b1, 8'h03);
    send(1'b0, 8'h44);
    chk("t3_strobe", 32'(tgt_strobe), 32'h8);
    chk("t3_start", 32'(tgt_start), 32'h1);
    send(1'b1, 8'h02);
    chk("restart_err", 32'(route_err), 32'h0);
    chk("restart_strobe", 32'(tgt_strobe), 32'h0);
    chk("restart_out", 32'(out_data), 32'hA5);
    chk("restart_active", 32'(active_tgt), 32'h2);
    send(1'b0, 8'h09);
    chk("t2_strobe", 32'(tgt_strobe), 32'h4);
    chk("t2_start", 32'(tgt_start), 32'h1);
    chk("t2_data", 32'(tgt_data), 32'h09);
    send(1'b0, 8'hAA);
    chk("b2b1_strobe", 32'(tgt_strobe), 32'h4);
    chk("b2b1_start", 32'(tgt_start), 32'h0);
    chk("b2b1_data", 32'(tgt_data), 32'hAA);
    send(1'b0, 8'hBB);
    chk("b2b2_strobe", 32'(tgt_strobe), 32'h4);
    chk("b2b2_data", 32'(tgt_data), 32'hBB);

`ifdef MCU_LINK_MSG_TIMEOUT_EN
    send(1'b1, 8'h00);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 15) chk("tmo_early", 32'(route_err), 32'h0);
      if (i == 16) begin
        chk("tmo_err", 32'(route_err), 32'h1);
        chk("tmo_out", 32'(out_data), 32'h00);
      end
      if (i == 17) chk("tmo_err_pulse", 32'(route_err), 32'h0);
    end
    send(1'b0, 8'h12);
    chk("tmo_idle_strobe", 32'(tgt_strobe), 32'h0);
`else
    repeat (20) @(negedge clk);
    send(1'b0, 8'hCD);
    chk("persist_strobe", 32'(tgt_strobe), 32'h4);
    chk("persist_data", 32'(tgt_data), 32'hCD);
    chk("persist_err", 32'(route_err), 32'h0);
`endif

    // One-cycle reset between two ROUTE bytes
    send(1'b1, 8'h01);
    send(1'b0, 8'h21);
    chk("pre_rst_strobe", 32'(tgt_strobe), 32'h2);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_strobe", 32'(tgt_strobe), 32'h0);
    chk("mid_rst_start", 32'(tgt_start), 32'h0);
    chk("mid_rst_data", 32'(tgt_data), 32'h0);
    chk("mid_rst_out", 32'(out_data), 32'h00);
    chk("mid_rst_active", 32'(active_tgt), 32'h0);
    send(1'b0, 8'h66);
    chk("post_rst_strobe", 32'(tgt_strobe), 32'h0);
    chk("post_rst_out", 32'(out_data), 32'h00);

    // in_start without in_strobe is ignored
    in_start = 1'b1;
    in_data  = 8'h02;
    @(negedge clk);
    in_start = 1'b0;
    chk("nostrobe_active", 32'(active_tgt), 32'h0);
    chk("nostrobe_out", 32'(out_data), 32'h00);
    send(1'b0, 8'h77);
    chk("nostrobe_fwd", 32'(tgt_strobe), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
